usb_rx_packet_engine: RTL and testbench
=======================================

// Module: usb_rx_packet_engine
// PURPOSE
// - Parametrised USB RX packet engine between the RX byte decoder and the AHB-Lite endpoint logic.
// - Checks the SYNC byte, the PID complement, CRC5 (tokens) and CRC16 (data), and decodes the packet type.
// - Streams DATA payload bytes into an internal FIFO. A packet's bytes become readable only when it passes.
// - A failing packet is rolled back completely; the reader never sees any of its bytes.
// PARAMETERS
// - FIFO_DEPTH   64     payload FIFO entries; power of 2, >=4
// - MAX_PAYLOAD  64     max DATA payload bytes; more -> ERROR
// - SYNC_BYTE    8'h80  required first byte of every packet
// PORTS
// - clk         in   1   clock, rising edge
// - rst         in   1   asynchronous active-high reset
// - byte_valid  in   1   1-cycle strobe per received byte
// - byte_data   in   8   received byte; bit0 = first bit on bus
// - eop         in   1   end-of-packet strobe; if coincident with byte_valid, the byte is processed first
// - rx_abort    in   1   decoder error (bit-stuff/line); kills the current packet
// - rx_packet   out  3   result: 0 IDLE, 1 IN, 2 OUT, 3 ACK, 4 ERROR, 5 DONE (good DATA), 6 NACK; held until next report
// - pkt_valid   out  1   1-cycle strobe; rx_packet and sidebands updated
// - data_pid    out  1   0 DATA0, 1 DATA1; valid with DONE
// - tok_addr    out  7   token address; valid with IN/OUT
// - tok_endp    out  4   token endpoint; valid with IN/OUT
// - pkt_len     out  $clog2(MAX_PAYLOAD+1)  committed payload bytes; valid with DONE
// - rd_en       in   1   pop FIFO head
// - rd_data     out  8   FIFO head, first-word fall-through; 0 when empty
// - fifo_empty  out  1   no committed bytes
// - fifo_count  out  $clog2(FIFO_DEPTH)+1  committed bytes
// - busy        out  1   FSM not in IDLE
// - err_count   out  16  ERROR reports; present only with RX_ERR_COUNT_EN
// BEHAVIOUR
// - Reset values: FSM IDLE; rx_packet=0, pkt_valid=0, data_pid=0, tok_addr=0, tok_endp=0, pkt_len=0.
// - Reset values (cont.): all pointers 0, fifo_empty=1, fifo_count=0, rd_data=0, busy=0.
// - Reset mid-packet discards everything, including committed FIFO data.
// - FSM states: IDLE, PID, TOKEN, DATA, HSK, DRAIN.
// - IDLE: on the first byte -> PID if the byte == SYNC_BYTE, else -> DRAIN.
// - PID: byte[7:4] != ~byte[3:0], or byte[3:0] not in {OUT 0001, IN 1001, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010} -> DRAIN.
// - PID: otherwise OUT/IN -> TOKEN, DATA0/DATA1 -> DATA, ACK/NAK -> HSK.
// - TOKEN: byte1 = {endp[0], addr[6:0]}; byte2 = {crc5[4:0], endp[3:1]}.
// - DRAIN: ignore bytes until eop, then report ERROR.
// - eop in any non-IDLE state: evaluate the packet, pkt_valid fires on the next cycle, FSM -> IDLE. eop in IDLE is ignored.
// - ERROR conditions (part 1): bad SYNC; bad or unsupported PID; TOKEN byte count != 2; CRC5 residual != 5'b01100.
// - ERROR conditions (part 2): DATA byte count < 2; CRC16 residual != 16'h800D; payload > MAX_PAYLOAD.
// - ERROR conditions (part 3): FIFO overflow; rx_abort while busy; HSK with extra bytes.
// - CRC: computed over all bytes after the PID, LSB first.
// - CRC5: poly 5'h05, init 5'h1F. CRC16: poly 16'h8005, init 16'hFFFF. The residual is checked over the whole field including the CRC.
// - Data path: a 2-byte holdoff register. A byte is written only after two later bytes arrive, so the CRC16 bytes are never stored.
// - Writes advance a speculative pointer. A good DONE copies it to the committed write pointer; any ERROR restores it from the committed pointer.
// - Overflow: a speculative write when committed + speculative entries == FIFO_DEPTH -> ERROR and rollback. Committed data stays intact.
// - fifo_count and fifo_empty reflect committed bytes only. The reader may pop during reception; rd_en while empty is ignored.
// - rd_en in the same cycle as a commit: both take effect (count = old - 1 + pkt_len).
// - pkt_len = DATA bytes - 2. A DATA packet with only PID + CRC gives DONE with pkt_len=0.
// - rx_abort while busy: immediate rollback; ERROR reported on the next cycle; FSM -> IDLE.
// CONFIGURATION
// - RX_ERR_COUNT_EN defined: err_count is a 16-bit saturating counter, +1 per ERROR report, reset to 0.
// - RX_ERR_COUNT_EN undefined: no err_count port and no counter logic.
// TESTING
// - 80,E1,token(addr 5, endp 1, valid CRC5),eop -> pkt_valid 1 cycle later; rx_packet=2, tok_addr=5, tok_endp=1.
// - 80,C3,01,02,03,good CRC16,eop -> DONE, data_pid=0, pkt_len=3; pops return 01,02,03, then fifo_empty=1.
// - Same packet with CRC16 corrupted -> ERROR, fifo_count stays 0, err_count=1 when enabled.
// - 80,D2,eop -> ACK; 80,5A,eop -> NACK; 80,D3,eop -> ERROR; 81,D2,eop -> ERROR.
// - FIFO_DEPTH=8 with 6 committed bytes, then DATA1 with 3 payload bytes -> ERROR; the 6 original bytes read back in order.
// - rx_abort after 2 DATA payload bytes -> ERROR next cycle, fifo_count=0; the following good packet is accepted; rst mid-packet -> IDLE, empty.

Source files
------------

// File: rtl/usb_rx_packet_engine.sv
// usb_rx_packet_engine
// Receives decoded USB bytes, checks SYNC, PID, CRC5 and CRC16, and reports
// the packet type. DATA payload bytes are written speculatively into a payload
// FIFO and become visible to the reader only when the packet passes; a
// failing packet is rolled back completely.
// Optional feature: define RX_ERR_COUNT_EN to add the 16-bit saturating
// err_count output that counts ERROR reports.
module usb_rx_packet_engine #(
    parameter int         FIFO_DEPTH  = 64,
    parameter int         MAX_PAYLOAD = 64,
    parameter logic [7:0] SYNC_BYTE   = 8'h80
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             byte_valid,
    input  logic [7:0]                       byte_data,
    input  logic                             eop,
    input  logic                             rx_abort,
    output logic [2:0]                       rx_packet,
    output logic                             pkt_valid,
    output logic                             data_pid,
    output logic [6:0]                       tok_addr,
    output logic [3:0]                       tok_endp,
    output logic [$clog2(MAX_PAYLOAD+1)-1:0] pkt_len,
    input  logic                             rd_en,
    output logic [7:0]                       rd_data,
    output logic                             fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
    output logic                             busy
`ifdef RX_ERR_COUNT_EN
    ,
    output logic [15:0]                      err_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(MAX_PAYLOAD + 1);
    localparam int CW = $clog2(MAX_PAYLOAD + 3);   // holds payload + 2 CRC bytes
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PAYLOAD + 2);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] R_IN    = 3'd1;
    localparam logic [2:0] R_OUT   = 3'd2;
    localparam logic [2:0] R_ACK   = 3'd3;
    localparam logic [2:0] R_ERROR = 3'd4;
    localparam logic [2:0] R_DONE  = 3'd5;
    localparam logic [2:0] R_NACK  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PID   = 3'd1,
        S_TOKEN = 3'd2,
        S_DATA  = 3'd3,
        S_HSK   = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    // CRC5 over one byte, LSB first, poly x^5+x^2+1
    function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic [7:0] data);
        logic [4:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[4] ^ data[i]) begin
                c = {c[3:0], 1'b0} ^ 5'h05;
            end else begin
                c = {c[3:0], 1'b0};
            end
        end
        return c;
    endfunction

    // CRC16 over one byte, LSB first, poly x^16+x^15+x^2+1
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h8005;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    state_t          state_q, state_d;
    logic [3:0]      pid_q, pid_d;
    logic [CW-1:0]   cnt_q, cnt_d;          // bytes received after the PID
    logic [4:0]      crc5_q, crc5_d;
    logic [15:0]     crc16_q, crc16_d;
    logic [7:0]      hold0_q, hold0_d;      // older holdoff byte (next to be written)
    logic [7:0]      hold1_q, hold1_d;
    logic [7:0]      tok_lo_q, tok_lo_d;    // token byte 1
    logic [2:0]      tok_hi_q, tok_hi_d;    // endp[3:1] from token byte 2
    logic [AW:0]     wr_spec_q, wr_spec_d;
    logic [AW:0]     wr_cmt_q, wr_cmt_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [2:0]      rx_packet_q, rx_packet_d;
    logic            pkt_valid_q, pkt_valid_d;
    logic            data_pid_q, data_pid_d;
    logic [6:0]      tok_addr_q, tok_addr_d;
    logic [3:0]      tok_endp_q, tok_endp_d;
    logic [LW-1:0]   pkt_len_q, pkt_len_d;

    logic            mem_we_s;
    logic [AW-1:0]   mem_waddr_s;
    logic [7:0]      mem_wdata_s;
    logic            report_s;
    logic [2:0]      report_code_s;
    logic [CW-1:0]   len_s;
    logic [AW:0]     occupancy_s;
    logic            fifo_empty_s;
    logic [7:0]      fifo_mem [FIFO_DEPTH];

    assign fifo_empty_s = (wr_cmt_q == rd_ptr_q);
    assign occupancy_s  = wr_spec_q - rd_ptr_q;

    // Next-state, datapath and report computation; bytes are applied before eop
    always_comb begin
        state_d       = state_q;
        pid_d         = pid_q;
        cnt_d         = cnt_q;
        crc5_d        = crc5_q;
        crc16_d       = crc16_q;
        hold0_d       = hold0_q;
        hold1_d       = hold1_q;
        tok_lo_d      = tok_lo_q;
        tok_hi_d      = tok_hi_q;
        wr_spec_d     = wr_spec_q;
        wr_cmt_d      = wr_cmt_q;
        rd_ptr_d      = rd_ptr_q;
        rx_packet_d   = rx_packet_q;
        pkt_valid_d   = 1'b0;
        data_pid_d    = data_pid_q;
        tok_addr_d    = tok_addr_q;
        tok_endp_d    = tok_endp_q;
        pkt_len_d     = pkt_len_q;
        mem_we_s      = 1'b0;
        mem_waddr_s   = wr_spec_q[AW-1:0];
        mem_wdata_s   = hold0_q;
        report_s      = 1'b0;
        report_code_s = R_ERROR;
        len_s         = {CW{1'b0}};

        // reader pops committed data independently of reception
        if (rd_en && !fifo_empty_s) begin
            rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if ((state_q != S_IDLE) && rx_abort) begin
            state_d       = S_IDLE;
            wr_spec_d     = wr_cmt_q;
            report_s      = 1'b1;
            report_code_s = R_ERROR;
        end else begin
            if (byte_valid) begin
                case (state_q)
                    S_IDLE: begin
                        cnt_d   = {CW{1'b0}};
                        crc5_d  = 5'h1F;
                        crc16_d = 16'hFFFF;
                        if (byte_data == SYNC_BYTE) begin
                            state_d = S_PID;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end
                    S_PID: begin
                        pid_d = byte_data[3:0];
                        if (byte_data[7:4] != ~byte_data[3:0]) begin
                            state_d = S_DRAIN;
                        end else begin
                            case (byte_data[3:0])
                                4'b0001, 4'b1001: state_d = S_TOKEN;
                                4'b0011, 4'b1011: state_d = S_DATA;
                                4'b0010, 4'b1010: state_d = S_HSK;
                                default:          state_d = S_DRAIN;
                            endcase
                        end
                    end
                    S_TOKEN: begin
                        if (cnt_q == CW'(2)) begin
                            state_d = S_DRAIN;
                        end else begin
                            cnt_d  = cnt_q + CW'(1);
                            crc5_d = crc5_step(crc5_q, byte_data);
                            if (cnt_q == CW'(0)) begin
                                tok_lo_d = byte_data;
                            end else begin
                                tok_hi_d = byte_data[2:0];
                            end
                        end
                    end
                    S_DATA: begin
                        if (cnt_q == CNT_MAX) begin
                            state_d   = S_DRAIN;
                            wr_spec_d = wr_cmt_q;
                        end else begin
                            cnt_d   = cnt_q + CW'(1);
                            crc16_d = crc16_step(crc16_q, byte_data);
                            hold0_d = hold1_q;
                            hold1_d = byte_data;
                            // the oldest held byte is known not to be CRC once two more arrive
                            if (cnt_q >= CW'(2)) begin
                                if (occupancy_s == DEPTH_L) begin
                                    state_d   = S_DRAIN;
                                    wr_spec_d = wr_cmt_q;
                                end else begin
                                    mem_we_s  = 1'b1;
                                    wr_spec_d = wr_spec_q + (AW + 1)'(1);
                                end
                            end else begin
                                mem_we_s = 1'b0;
                            end
                        end
                    end
                    S_HSK:   state_d = S_DRAIN;
                    S_DRAIN: state_d = S_DRAIN;
                    default: state_d = S_IDLE;
                endcase
            end else begin
                state_d = state_q;
            end

            if (eop && (state_d != S_IDLE)) begin
                case (state_d)
                    S_TOKEN: begin
                        if ((cnt_d == CW'(2)) && (crc5_d == 5'b01100)) begin
                            report_code_s = (pid_d == 4'b1001) ? R_IN : R_OUT;
                            tok_addr_d    = tok_lo_d[6:0];
                            tok_endp_d    = {tok_hi_d, tok_lo_d[7]};
                        end else begin
                            report_code_s = R_ERROR;
                        end
                    end
                    S_DATA: begin
                        if ((cnt_d >= CW'(2)) && (crc16_d == 16'h800D)) begin
                            report_code_s = R_DONE;
                            len_s         = cnt_d - CW'(2);
                            pkt_len_d     = len_s[LW-1:0];
                            data_pid_d    = pid_d[3];
                            wr_cmt_d      = wr_spec_d;
                        end else begin
                            report_code_s = R_ERROR;
                        end
                    end
                    S_HSK: begin
                        report_code_s = (pid_d == 4'b0010) ? R_ACK : R_NACK;
                    end
                    default: report_code_s = R_ERROR;
                endcase
                if (report_code_s == R_ERROR) begin
                    wr_spec_d = wr_cmt_q;
                end else begin
                    wr_spec_d = wr_spec_d;
                end
                report_s = 1'b1;
                state_d  = S_IDLE;
            end else begin
                report_s = 1'b0;
            end
        end

        if (report_s) begin
            pkt_valid_d = 1'b1;
            rx_packet_d = report_code_s;
        end else begin
            pkt_valid_d = 1'b0;
        end
    end

    // State, pointer and report registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pid_q       <= 4'd0;
            cnt_q       <= {CW{1'b0}};
            crc5_q      <= 5'h1F;
            crc16_q     <= 16'hFFFF;
            hold0_q     <= 8'd0;
            hold1_q     <= 8'd0;
            tok_lo_q    <= 8'd0;
            tok_hi_q    <= 3'd0;
            wr_spec_q   <= {(AW + 1){1'b0}};
            wr_cmt_q    <= {(AW + 1){1'b0}};
            rd_ptr_q    <= {(AW + 1){1'b0}};
            rx_packet_q <= 3'd0;
            pkt_valid_q <= 1'b0;
            data_pid_q  <= 1'b0;
            tok_addr_q  <= 7'd0;
            tok_endp_q  <= 4'd0;
            pkt_len_q   <= {LW{1'b0}};
        end else begin
            state_q     <= state_d;
            pid_q       <= pid_d;
            cnt_q       <= cnt_d;
            crc5_q      <= crc5_d;
            crc16_q     <= crc16_d;
            hold0_q     <= hold0_d;
            hold1_q     <= hold1_d;
            tok_lo_q    <= tok_lo_d;
            tok_hi_q    <= tok_hi_d;
            wr_spec_q   <= wr_spec_d;
            wr_cmt_q    <= wr_cmt_d;
            rd_ptr_q    <= rd_ptr_d;
            rx_packet_q <= rx_packet_d;
            pkt_valid_q <= pkt_valid_d;
            data_pid_q  <= data_pid_d;
            tok_addr_q  <= tok_addr_d;
            tok_endp_q  <= tok_endp_d;
            pkt_len_q   <= pkt_len_d;
        end
    end

    // Payload storage; stale entries are never visible because reads are gated by the committed pointer
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            fifo_mem[mem_waddr_s] <= mem_wdata_s;
        end
    end

`ifdef RX_ERR_COUNT_EN
    logic [15:0] err_count_q, err_count_d;

    // Saturating count of ERROR reports
    always_comb begin
        err_count_d = err_count_q;
        if (report_s && (report_code_s == R_ERROR) && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Error counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q <= 16'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

    assign rx_packet  = rx_packet_q;
    assign pkt_valid  = pkt_valid_q;
    assign data_pid   = data_pid_q;
    assign tok_addr   = tok_addr_q;
    assign tok_endp   = tok_endp_q;
    assign pkt_len    = pkt_len_q;
    assign fifo_empty = fifo_empty_s;
    assign fifo_count = wr_cmt_q - rd_ptr_q;
    assign rd_data    = fifo_empty_s ? 8'd0 : fifo_mem[rd_ptr_q[AW-1:0]];
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_usb_rx_packet_engine.sv
// Self-checking bench for usb_rx_packet_engine: directed cases from the
// packet rules followed by randomized packets checked against a queue model.
module tb_usb_rx_packet_engine;

    localparam int DEPTH = 64;
    localparam int MAXP  = 64;
    localparam int C_IN = 1, C_OUT = 2, C_ACK = 3, C_ERR = 4, C_DONE = 5, C_NACK = 6;

    logic        clk = 1'b0;
    logic        rst, byte_valid, eop, rx_abort, rd_en;
    logic [7:0]  byte_data;
    logic [2:0]  rx_packet;
    logic        pkt_valid, data_pid, fifo_empty, busy;
    logic [6:0]  tok_addr;
    logic [3:0]  tok_endp;
    logic [6:0]  pkt_len;
    logic [7:0]  rd_data;
    logic [6:0]  fifo_count;
`ifdef RX_ERR_COUNT_EN
    logic [15:0] err_count;
`endif

    int tests = 0;
    int failed = 0;
    int exp_err = 0;
    int exp_code, exp_len, exp_addr, exp_endp, exp_dpid;
    logic [7:0] pkt[$];
    logic [7:0] model_q[$];
    logic [7:0] exp_pay[$];
    logic [7:0] pay[$];

    usb_rx_packet_engine #(.FIFO_DEPTH(DEPTH), .MAX_PAYLOAD(MAXP), .SYNC_BYTE(8'h80)) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .eop(eop), .rx_abort(rx_abort), .rx_packet(rx_packet), .pkt_valid(pkt_valid),
        .data_pid(data_pid), .tok_addr(tok_addr), .tok_endp(tok_endp), .pkt_len(pkt_len),
        .rd_en(rd_en), .rd_data(rd_data), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
        .busy(busy)
`ifdef RX_ERR_COUNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Shift-register CRC over the first nbits of d, LSB of each byte first
    function automatic logic [15:0] ref_crc(input int w, input logic [15:0] poly,
                                            input logic [15:0] init, input logic [7:0] d[$],
                                            input int nbits);
        logic [15:0] c;
        logic [7:0]  cur;
        logic        msb;
        c = init;
        for (int i = 0; i < nbits; i++) begin
            cur = d[i / 8];
            msb = c[w - 1];
            c = c << 1;
            if (msb ^ cur[i % 8]) c = c ^ poly;
            c = c & ((16'h1 << w) - 16'h1);
        end
        return c;
    endfunction

    task automatic make_token(input logic [7:0] pid, input logic [6:0] addr, input logic [3:0] endp);
        logic [7:0] f[$];
        logic [7:0] b1, b2;
        logic [15:0] c;
        b1 = {endp[0], addr};
        b2 = {5'd0, endp[3:1]};
        f.push_back(b1);
        f.push_back(b2);
        c = ~ref_crc(5, 16'h0005, 16'h001F, f, 11);
        b2[7:3] = {c[0], c[1], c[2], c[3], c[4]};
        pkt = {8'h80, pid, b1, b2};
    endtask

    task automatic make_data(input logic [7:0] pid);
        logic [15:0] c;
        logic [7:0]  b0, b1;
        c = ~ref_crc(16, 16'h8005, 16'hFFFF, pay, 8 * pay.size());
        for (int k = 0; k < 8; k++) begin
            b0[k] = c[15 - k];
            b1[k] = c[7 - k];
        end
        pkt = {8'h80, pid};
        foreach (pay[i]) pkt.push_back(pay[i]);
        pkt.push_back(b0);
        pkt.push_back(b1);
    endtask

    task automatic rand_pay(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
    endtask

    // Reference: packet outcome from the byte list and current committed occupancy
    task automatic predict();
        int n, r;
        logic [7:0] p, r0, r1;
        logic [7:0] rest[$];
        n = pkt.size();
        exp_code = C_ERR;
        exp_pay.delete();
        if (n >= 2 && pkt[0] == 8'h80) begin
            p = pkt[1];
            for (int i = 2; i < n; i++) rest.push_back(pkt[i]);
            r = n - 2;
            if (p[7:4] == ~p[3:0]) begin
                case (p[3:0])
                    4'b0001, 4'b1001: begin
                        if (r == 2 && ref_crc(5, 16'h0005, 16'h001F, rest, 16) == 16'h000C) begin
                            r0 = rest[0];
                            r1 = rest[1];
                            exp_code = (p[3:0] == 4'b1001) ? C_IN : C_OUT;
                            exp_addr = int'(r0[6:0]);
                            exp_endp = int'({r1[2:0], r0[7]});
                        end
                    end
                    4'b0011, 4'b1011: begin
                        if (r >= 2 && r - 2 <= MAXP &&
                            ref_crc(16, 16'h8005, 16'hFFFF, rest, 8 * r) == 16'h800D &&
                            model_q.size() + r - 2 <= DEPTH) begin
                            exp_code = C_DONE;
                            exp_len  = r - 2;
                            exp_dpid = int'(p[3]);
                            for (int i = 0; i < r - 2; i++) exp_pay.push_back(rest[i]);
                        end
                    end
                    4'b0010: if (r == 0) exp_code = C_ACK;
                    4'b1010: if (r == 0) exp_code = C_NACK;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_report(input string tag);
        chk({tag, "_valid"}, pkt_valid, 1);
        chk({tag, "_type"}, rx_packet, exp_code);
        if (exp_code == C_IN || exp_code == C_OUT) begin
            chk({tag, "_addr"}, tok_addr, exp_addr);
            chk({tag, "_endp"}, tok_endp, exp_endp);
        end
        if (exp_code == C_DONE) begin
            chk({tag, "_len"}, pkt_len, exp_len);
            chk({tag, "_dpid"}, data_pid, exp_dpid);
        end
        chk({tag, "_count"}, fifo_count, model_q.size());
        chk({tag, "_empty"}, fifo_empty, model_q.size() == 0);
`ifdef RX_ERR_COUNT_EN
        if (exp_code == C_ERR) exp_err++;
        chk({tag, "_errcnt"}, err_count, exp_err);
`endif
        tick();
        chk({tag, "_strobe_off"}, pkt_valid, 0);
        chk({tag, "_held"}, rx_packet, exp_code);
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic run_pkt(input string tag, input bit coinc, input bit pop_eop);
        int n;
        predict();
        n = pkt.size();
        for (int i = 0; i < n; i++) begin
            byte_valid = 1'b1;
            byte_data  = pkt[i];
            if (coinc && i == n - 1) begin
                eop   = 1'b1;
                rd_en = pop_eop;
                if (pop_eop && model_q.size() > 0) chk({tag, "_eop_head"}, rd_data, model_q[0]);
            end
            tick();
            byte_valid = 1'b0;
            eop        = 1'b0;
            rd_en      = 1'b0;
            if (i < n - 1 && $urandom_range(0, 3) == 0) tick();
        end
        if (!coinc) begin
            eop   = 1'b1;
            rd_en = pop_eop;
            if (pop_eop && model_q.size() > 0) chk({tag, "_eop_head"}, rd_data, model_q[0]);
            tick();
            eop   = 1'b0;
            rd_en = 1'b0;
        end
        if (pop_eop && model_q.size() > 0) void'(model_q.pop_front());
        if (exp_code == C_DONE) foreach (exp_pay[i]) model_q.push_back(exp_pay[i]);
        check_report(tag);
    endtask

    task automatic pop_n(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            if (model_q.size() == 0) break;
            chk({tag, "_rd"}, rd_data, model_q[0]);
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            void'(model_q.pop_front());
        end
        chk({tag, "_cnt"}, fifo_count, model_q.size());
    endtask

    task automatic run_abort(input string tag, input int k);
        pkt = {8'h80, ($urandom_range(0, 1) != 0) ? 8'h4B : 8'hC3};
        for (int i = 0; i < k; i++) pkt.push_back(8'($urandom_range(0, 255)));
        foreach (pkt[i]) begin
            byte_valid = 1'b1;
            byte_data  = pkt[i];
            tick();
            byte_valid = 1'b0;
        end
        rx_abort = 1'b1;
        tick();
        rx_abort = 1'b0;
        exp_code = C_ERR;
        check_report(tag);
    endtask

    initial begin
        int kind, len;
        logic [7:0] pid;
        rst = 1'b1; byte_valid = 1'b0; byte_data = 8'd0; eop = 1'b0; rx_abort = 1'b0; rd_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_rx_packet", rx_packet, 0);
        chk("rst_pkt_valid", pkt_valid, 0);
        chk("rst_data_pid", data_pid, 0);
        chk("rst_tok_addr", tok_addr, 0);
        chk("rst_tok_endp", tok_endp, 0);
        chk("rst_pkt_len", pkt_len, 0);
        chk("rst_fifo_empty", fifo_empty, 1);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_busy", busy, 0);
`ifdef RX_ERR_COUNT_EN
        chk("rst_err_count", err_count, 0);
`endif

        // OUT token addr 5 endp 1
        make_token(8'hE1, 7'd5, 4'd1);
        run_pkt("tok_out", 1'b0, 1'b0);
        chk("tok_out_const", rx_packet, C_OUT);
        chk("tok_out_addr_const", tok_addr, 5);
        chk("tok_out_endp_const", tok_endp, 1);

        // DATA0 01 02 03 then pop back
        pay = {8'h01, 8'h02, 8'h03};
        make_data(8'hC3);
        run_pkt("data3", 1'b0, 1'b0);
        chk("data3_const", rx_packet, C_DONE);
        chk("data3_len_const", pkt_len, 3);
        pop_n("data3_pop", 3);
        chk("data3_empty", fifo_empty, 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("pop_empty_cnt", fifo_count, 0);

        // Same packet with CRC corrupted
        make_data(8'hC3);
        pkt[6] = pkt[6] ^ 8'h10;
        run_pkt("data_badcrc", 1'b0, 1'b0);
        chk("data_badcrc_const", rx_packet, C_ERR);
        chk("data_badcrc_cnt", fifo_count, 0);

        pkt = {8'h80, 8'hD2}; run_pkt("ack", 1'b0, 1'b0);  chk("ack_const", rx_packet, C_ACK);
        pkt = {8'h80, 8'h5A}; run_pkt("nack", 1'b1, 1'b0); chk("nack_const", rx_packet, C_NACK);
        pkt = {8'h80, 8'hD3}; run_pkt("badpid", 1'b0, 1'b0); chk("badpid_const", rx_packet, C_ERR);
        pkt = {8'h81, 8'hD2}; run_pkt("badsync", 1'b0, 1'b0); chk("badsync_const", rx_packet, C_ERR);
        pkt = {8'h80, 8'hD2, 8'h00}; run_pkt("hsk_extra", 1'b0, 1'b0); chk("hsk_extra_const", rx_packet, C_ERR);

        // Zero-length DATA1
        pay.delete();
        make_data(8'h4B);
        run_pkt("data0len", 1'b1, 1'b0);
        chk("data0len_const", rx_packet, C_DONE);
        chk("data0len_len", pkt_len, 0);
        chk("data0len_pid", data_pid, 1);

        // Max payload accepted, one over rejected
        rand_pay(MAXP); make_data(8'hC3);
        run_pkt("maxp", 1'b0, 1'b0); chk("maxp_const", rx_packet, C_DONE);
        pop_n("maxp_pop", DEPTH);
        rand_pay(MAXP + 1); make_data(8'hC3);
        run_pkt("overmax", 1'b0, 1'b0); chk("overmax_const", rx_packet, C_ERR);

        // Fill to exactly full, then overflow; committed bytes survive
        rand_pay(60); make_data(8'hC3); run_pkt("fill60", 1'b0, 1'b0);
        rand_pay(4);  make_data(8'h4B); run_pkt("fill64", 1'b1, 1'b0);
        chk("fill64_cnt_const", fifo_count, 64);
        rand_pay(1);  make_data(8'h4B); run_pkt("ovf", 1'b0, 1'b0);
        chk("ovf_const", rx_packet, C_ERR);
        pop_n("ovf_readback", DEPTH);
        chk("ovf_readback_empty", fifo_empty, 1);

        // Abort after 2 payload bytes, then a good packet
        run_abort("abort2", 2);
        chk("abort2_cnt_const", fifo_count, 0);
        rand_pay(2); make_data(8'hC3); run_pkt("after_abort", 1'b0, 1'b0);
        chk("after_abort_const", rx_packet, C_DONE);

        // Abort while idle is ignored
        rx_abort = 1'b1; tick(); rx_abort = 1'b0;
        chk("abort_idle_valid", pkt_valid, 0);
        chk("abort_idle_busy", busy, 0);

        // Randomized packets
        for (int it = 0; it < 150; it++) begin
            kind = $urandom_range(0, 10);
            case (kind)
                0, 1: begin
                    make_token(($urandom_range(0, 1) != 0) ? 8'h69 : 8'hE1,
                               7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)));
                    if (kind == 1) pkt[$urandom_range(2, 3)] ^= 8'(1 << $urandom_range(0, 7));
                end
                2: begin
                    make_token(8'h69, 7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)));
                    if ($urandom_range(0, 1) != 0) pkt.push_back(8'h00);
                    else void'(pkt.pop_back());
                end
                3, 4, 5, 9: begin
                    len = (kind == 9) ? $urandom_range(0, 24) : $urandom_range(0, 8);
                    rand_pay(len);
                    make_data(($urandom_range(0, 1) != 0) ? 8'h4B : 8'hC3);
                    if (kind == 5) pkt[$urandom_range(2, pkt.size() - 1)] ^= 8'(1 << $urandom_range(0, 7));
                end
                6: begin
                    pkt = {8'h80, ($urandom_range(0, 1) != 0) ? 8'hD2 : 8'h5A};
                    if ($urandom_range(0, 3) == 0) pkt.push_back(8'($urandom_range(0, 255)));
                end
                7: begin
                    pid = 8'($urandom_range(0, 255));
                    pkt = {8'h80, pid};
                end
                8: begin
                    pid = 8'($urandom_range(0, 255));
                    if (pid == 8'h80) pid = 8'h00;
                    pkt = {pid, 8'hD2};
                end
                default: ;
            endcase
            if (kind == 10) run_abort("rnd_abort", $urandom_range(0, 5));
            else run_pkt("rnd", $urandom_range(0, 1) != 0, $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 2) == 0) pop_n("rnd_pop", $urandom_range(0, 12));
        end

        // Reset in the middle of a packet discards everything
        pop_n("pre_rst", DEPTH);
        rand_pay(5); make_data(8'hC3); run_pkt("pre_rst_pkt", 1'b0, 1'b0);
        pkt = {8'h80, 8'hC3, 8'h11, 8'h22, 8'h33};
        foreach (pkt[i]) begin
            byte_valid = 1'b1; byte_data = pkt[i]; tick(); byte_valid = 1'b0;
        end
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        #2;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_empty", fifo_empty, 1);
        chk("mid_rst_cnt", fifo_count, 0);
        chk("mid_rst_rd_data", rd_data, 0);
        tick();
        rst = 1'b0;
        model_q.delete();
        exp_err = 0;
        tick();
        chk("post_rst_valid", pkt_valid, 0);
        rand_pay(3); make_data(8'h4B); run_pkt("post_rst_pkt", 1'b1, 1'b0);
        chk("post_rst_pkt_const", rx_packet, C_DONE);
        pop_n("post_rst_pop", 3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
